// File: rtl/aidc_lite_apb_pkg.sv
// rtl/aidc_lite_apb_pkg.sv - shared types and widths for the AIDC-Lite APB requester
package aidc_lite_apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_req_state_t;

  // Completers decode word addresses only, so the byte offset is dropped at capture.
  function automatic logic [APB_AW-1:0] word_align(input logic [APB_AW-1:0] addr);
    return addr & ~APB_AW'(3);
  endfunction

endpackage

// File: rtl/aidc_lite_apb_requester.sv
// rtl/aidc_lite_apb_requester.sv - APB requester turning one valid/ready command into one APB transfer
module aidc_lite_apb_requester
  import aidc_lite_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [APB_AW-1:0] req_addr_i,
  input  logic [APB_DW-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [APB_DW-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              psel,
  output logic              penable,
  output logic [APB_AW-1:0] paddr,
  output logic              pwrite,
  output logic [APB_DW-1:0] pwdata,
  input  logic [APB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam bit            TO_EN    = (TIMEOUT_CYC != 0);
  localparam int            CW       = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

  apb_req_state_t state, state_n;
  logic [CW-1:0]  wait_cnt;
  logic           accept, done, abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ready is a flop so it stays low in reset; gate accept with it for the first cycle after release
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_n = RESP;
        end else if (TO_EN && wait_cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // APB strobes are registered from the next state so nothing on req_* reaches the bus combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel          <= 1'b0;
      penable       <= 1'b0;
      paddr         <= '0;
      pwrite        <= 1'b0;
      pwdata        <= '0;
      req_ready_o   <= 1'b0;
      wait_cnt      <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      psel        <= (state_n == SETUP) || (state_n == ACCESS);
      penable     <= (state_n == ACCESS);
      req_ready_o <= (state_n == IDLE);

      if (accept) begin
        paddr    <= word_align(req_addr_i);
        pwrite   <= req_write_i;
        pwdata   <= req_wdata_i;
        wait_cnt <= '0;
      end else if (state == ACCESS && !pready && wait_cnt != {CW{1'b1}}) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      if (done) begin
        rsp_rdata_o   <= pwrite ? '0 : prdata;
        rsp_err_o     <= pslverr;
        rsp_timeout_o <= 1'b0;
      end else if (abort) begin
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end
    end
  end

  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_aidc_lite_apb_requester.sv
// tb/tb_aidc_lite_apb_requester.sv - self-checking bench for aidc_lite_apb_requester
module tb_aidc_lite_apb_requester;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_wait;

  always #5 clk = ~clk;

  aidc_lite_apb_requester #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr, wdata, prdata;
    bit          slverr;
    int          waits;      // ACCESS cycles with pready low before the completer answers
    int          stall;      // cycles rsp_ready stays low while the response is offered
    bit          keep_valid;
    logic [31:0] exp_paddr, exp_rdata;
    bit          exp_err, exp_to;
    int          exp_acc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, int wt, logic [31:0] rd,
                              bit se, int st, logic [31:0] ea, logic [31:0] er, bit ee,
                              bit et, int eacc);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.waits = wt; v.prdata = rd; v.slverr = se;
    v.stall = st; v.keep_valid = 1'b0;
    v.exp_paddr = ea; v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_acc = eacc;
    return v;
  endfunction

  // Reference: a transfer answers after waits+1 ACCESS cycles unless that exceeds T.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    r.exp_paddr = v.addr & 32'hFFFF_FFFC;
    r.exp_to    = (v.waits >= T);
    r.exp_acc   = r.exp_to ? T : v.waits + 1;
    r.exp_err   = r.exp_to | v.slverr;
    r.exp_rdata = (r.exp_to || v.write) ? 32'h0 : v.prdata;
    return r;
  endfunction

  task automatic do_xfer(input vec_t v, input string tag);
    int n;
    int acc;
    req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ready_wait = n;
    check({tag, " req_ready"}, 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;
    if (!v.keep_valid) req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    check({tag, " setup psel"}, 32'(psel), 32'h1);
    check({tag, " setup penable"}, 32'(penable), 32'h0);
    check({tag, " paddr"}, paddr, v.exp_paddr);
    check({tag, " pwrite"}, 32'(pwrite), 32'(v.write));
    check({tag, " pwdata"}, pwdata, v.wdata);
    check({tag, " busy"}, 32'(busy_o), 32'h1);
    check({tag, " ready low"}, 32'(req_ready_o), 32'h0);
    @(posedge clk); #1;
    acc = 0;
    while (psel === 1'b1 && penable === 1'b1 && acc < 40) begin
      acc++;
      check({tag, " access paddr"}, paddr, v.exp_paddr);
      pready  = (acc == v.waits + 1);
      prdata  = pready ? v.prdata : $urandom;
      pslverr = pready ? v.slverr : 1'($urandom);
      @(posedge clk); #1;
    end
    pready = 1'b0;
    check({tag, " access cycles"}, 32'(acc), 32'(v.exp_acc));
    for (int i = 0; i <= v.stall; i++) begin
      rsp_ready = (i == v.stall);
      check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'h1);
      check({tag, " rsp_rdata"}, rsp_rdata_o, v.exp_rdata);
      check({tag, " rsp_err"}, 32'(rsp_err_o), 32'(v.exp_err));
      check({tag, " rsp_timeout"}, 32'(rsp_timeout_o), 32'(v.exp_to));
      check({tag, " resp psel"}, 32'({psel, penable}), 32'h0);
      check({tag, " resp ready"}, 32'(req_ready_o), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check({tag, " rsp dropped"}, 32'(rsp_valid_o), 32'h0);
    check({tag, " idle ready"}, 32'(req_ready_o), 32'h1);
    check({tag, " idle psel"}, 32'(psel), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " psel"}, 32'(psel), 32'h0);
    check({tag, " penable"}, 32'(penable), 32'h0);
    check({tag, " paddr"}, paddr, 32'h0);
    check({tag, " pwrite"}, 32'(pwrite), 32'h0);
    check({tag, " pwdata"}, pwdata, 32'h0);
    check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    check({tag, " rsp_rdata"}, rsp_rdata_o, 32'h0);
    check({tag, " rsp_err"}, 32'({rsp_err_o, rsp_timeout_o}), 32'h0);
    check({tag, " busy"}, 32'(busy_o), 32'h0);
    check({tag, " req_ready"}, 32'(req_ready_o), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir[7];
    vec_t v;
    int   n;

    dir[0] = mk(1, 32'h4,         32'h1000_0000, 0,    32'hCAFE_0000, 0, 0, 32'h4,         32'h0,         0, 0, 1);
    dir[1] = mk(0, 32'h13,        32'h0,         3,    32'h1,         0, 0, 32'h10,        32'h1,         0, 0, 4);
    dir[2] = mk(0, 32'h20,        32'h0,         1,    32'hDEAD_BEEF, 1, 1, 32'h20,        32'hDEAD_BEEF, 1, 0, 2);
    dir[3] = mk(0, 32'h30,        32'h0,         1000, 32'h77,        0, 0, 32'h30,        32'h0,         1, 1, 8);
    dir[4] = mk(0, 32'h37,        32'h0,         7,    32'h55,        0, 0, 32'h34,        32'h55,        0, 0, 8);
    dir[5] = mk(1, 32'h3C,        32'hA5A5_5A5A, 8,    32'h9,         1, 2, 32'h3C,        32'h0,         1, 1, 8);
    dir[6] = mk(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,    32'h0,         1, 0, 32'hFFFF_FFFC, 32'h0,         1, 0, 3);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    foreach (dir[i]) do_xfer(dir[i], $sformatf("dir%0d", i));

    // Response back-pressure with the next command already waiting.
    v = mk(1, 32'h40, 32'h1234_5678, 0, 32'h0, 0, 5, 32'h40, 32'h0, 0, 0, 1);
    v.keep_valid = 1'b1;
    do_xfer(v, "bp1");
    v = mk(0, 32'h44, 32'h0, 0, 32'h0BAD_F00D, 0, 0, 32'h44, 32'h0BAD_F00D, 0, 0, 1);
    do_xfer(v, "bp2");
    check("bp2 back-to-back accept", 32'(ready_wait), 32'h0);

    // Reset asserted in the middle of ACCESS.
    req_write = 1'b1; req_addr = 32'h50; req_wdata = 32'h5555_AAAA; req_valid = 1'b1;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_access penable before", 32'(penable), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_access");
    @(posedge clk); #3 rst_n = 1'b1;
    v = mk(0, 32'h8, 32'h0, 0, 32'h1234_ABCD, 0, 0, 32'h8, 32'h1234_ABCD, 0, 0, 1);
    do_xfer(v, "after_rst");

    // Reset while a response is being offered.
    req_write = 1'b0; req_addr = 32'h60; req_valid = 1'b1;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    pready = 1'b1; prdata = 32'hFEED_0001;
    @(posedge clk); #1;
    pready = 1'b0;
    check("rst_resp valid before", 32'(rsp_valid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_resp");
    @(posedge clk); #3 rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      v.write      = 1'($urandom);
      v.addr       = $urandom;
      v.wdata      = $urandom;
      v.prdata     = $urandom;
      v.slverr     = ($urandom_range(0, 3) == 0);
      v.waits      = int'($urandom_range(0, 10));
      v.stall      = int'($urandom_range(0, 3));
      v.keep_valid = 1'b0;
      v = model(v);
      do_xfer(v, $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
